// File: rtl/cp0_exc_ctrl_pkg.sv
// Shared constants and types for the CP0 exception sequencer.
// Optional feature macro used by the RTL: CP0_EXC_BADVADDR_EN.
package cp0_exc_ctrl_pkg;

  localparam logic [4:0] CP0_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_STATUS   = 5'd12;
  localparam logic [4:0] CP0_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_EPC      = 5'd14;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;
  localparam logic [4:0] EXC_TR   = 5'd13;

  localparam int unsigned ET_SYSCALL  = 8;
  localparam int unsigned ET_INVALID  = 9;
  localparam int unsigned ET_TRAP     = 10;
  localparam int unsigned ET_OVERFLOW = 11;
  localparam int unsigned ET_ERET     = 12;
  localparam int unsigned ET_ADEL     = 13;
  localparam int unsigned ET_ADES     = 14;

  localparam int unsigned STATUS_IE  = 0;
  localparam int unsigned STATUS_EXL = 1;

  typedef enum logic [2:0] {
    IDLE,
    WR_BADVADDR,
    WR_EPC,
    WR_CAUSE,
    WR_STATUS,
    REDIRECT
  } state_e;

  typedef struct packed {
    logic       hit;
    logic       is_eret;
    logic [4:0] code;
  } exc_req_t;

  // Context captured at detection; the commit replays it over several cycles.
  typedef struct packed {
    logic [31:0] pc;
    logic        in_ds;
    logic [4:0]  code;
    logic        is_eret;
    logic [31:0] cause;
    logic [31:0] status;
    logic [31:0] epc;
    logic [31:0] badvaddr;
  } exc_ctx_t;

endpackage

// File: rtl/cp0_exc_ctrl_prio_enc.sv
// Forwarding of WB-stage mtc0 data onto Status/Cause/EPC plus exception priority encoder.
// CP0_EXC_BADVADDR_EN enables recognition of AdEL/AdES.
import cp0_exc_ctrl_pkg::*;

module exc_prio_enc (
  input  logic        valid_i,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] status_i,
  input  logic [31:0] cause_i,
  input  logic [31:0] epc_i,
  input  logic        wb_cp0_we_i,
  input  logic [4:0]  wb_cp0_waddr_i,
  input  logic [31:0] wb_cp0_data_i,
  output logic [31:0] eff_status_o,
  output logic [31:0] eff_cause_o,
  output logic [31:0] eff_epc_o,
  output exc_req_t    req_o
);

  logic int_pending;

  always_comb begin
    eff_status_o = (wb_cp0_we_i && wb_cp0_waddr_i == CP0_STATUS) ? wb_cp0_data_i : status_i;
    eff_cause_o  = (wb_cp0_we_i && wb_cp0_waddr_i == CP0_CAUSE)  ? wb_cp0_data_i : cause_i;
    eff_epc_o    = (wb_cp0_we_i && wb_cp0_waddr_i == CP0_EPC)    ? wb_cp0_data_i : epc_i;
  end

  always_comb begin
    int_pending = ((eff_cause_o[15:8] & eff_status_o[15:8]) != 8'h00) &&
                  eff_status_o[STATUS_IE] && !eff_status_o[STATUS_EXL];
  end

  always_comb begin
    req_o = '0;
    if (valid_i) begin
      if (int_pending) begin
        req_o.hit  = 1'b1;
        req_o.code = EXC_INT;
      end
`ifdef CP0_EXC_BADVADDR_EN
      else if (excepttype_i[ET_ADEL]) begin
        req_o.hit  = 1'b1;
        req_o.code = EXC_ADEL;
      end else if (excepttype_i[ET_ADES]) begin
        req_o.hit  = 1'b1;
        req_o.code = EXC_ADES;
      end
`endif
      else if (excepttype_i[ET_SYSCALL]) begin
        req_o.hit  = 1'b1;
        req_o.code = EXC_SYS;
      end else if (excepttype_i[ET_INVALID]) begin
        req_o.hit  = 1'b1;
        req_o.code = EXC_RI;
      end else if (excepttype_i[ET_TRAP]) begin
        req_o.hit  = 1'b1;
        req_o.code = EXC_TR;
      end else if (excepttype_i[ET_OVERFLOW]) begin
        req_o.hit  = 1'b1;
        req_o.code = EXC_OV;
      end else if (excepttype_i[ET_ERET]) begin
        req_o.hit     = 1'b1;
        req_o.is_eret = 1'b1;
      end
    end
  end

  logic unused_bits;
`ifdef CP0_EXC_BADVADDR_EN
  assign unused_bits = ^{excepttype_i[31:15], excepttype_i[7:0]};
`else
  assign unused_bits = ^{excepttype_i[31:13], excepttype_i[7:0]};
`endif

endmodule

// File: rtl/cp0_exc_ctrl.sv
// CP0 exception sequencer: detect, commit EPC/Cause/Status, then flush and redirect (4 cycles, 2 for eret).
// CP0_EXC_BADVADDR_EN adds a BadVAddr write ahead of EPC for address-error exceptions.
import cp0_exc_ctrl_pkg::*;

module cp0_exc_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0020
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] pc_i,
  input  logic        in_delayslot_i,
  input  logic [31:0] badvaddr_i,
  input  logic [31:0] status_i,
  input  logic [31:0] cause_i,
  input  logic [31:0] epc_i,
  input  logic        wb_cp0_we_i,
  input  logic [4:0]  wb_cp0_waddr_i,
  input  logic [31:0] wb_cp0_data_i,
  output logic        cp0_we_o,
  output logic [4:0]  cp0_waddr_o,
  output logic [31:0] cp0_data_o,
  output logic        cp0_hw_o,
  output logic        stall_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o,
  output logic        busy_o
);

  state_e      state_q, state_d;
  exc_ctx_t    ctx_q, ctx_d;
  exc_req_t    req;
  logic [31:0] eff_status, eff_cause, eff_epc;
  logic        det;

  exc_prio_enc u_prio (
    .valid_i        (valid_i),
    .excepttype_i   (excepttype_i),
    .status_i       (status_i),
    .cause_i        (cause_i),
    .epc_i          (epc_i),
    .wb_cp0_we_i    (wb_cp0_we_i),
    .wb_cp0_waddr_i (wb_cp0_waddr_i),
    .wb_cp0_data_i  (wb_cp0_data_i),
    .eff_status_o   (eff_status),
    .eff_cause_o    (eff_cause),
    .eff_epc_o      (eff_epc),
    .req_o          (req)
  );

  // Only IDLE accepts requests, which also suppresses detection during the flush cycle.
  assign det = req.hit && !rst && (state_q == IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
    ctx_q <= ctx_d;
  end

  always_comb begin
    state_d = state_q;
    ctx_d   = ctx_q;
    unique case (state_q)
      IDLE: begin
        if (det) begin
          ctx_d.pc      = pc_i;
          ctx_d.in_ds   = in_delayslot_i;
          ctx_d.code    = req.code;
          ctx_d.is_eret = req.is_eret;
          ctx_d.cause   = eff_cause;
          ctx_d.status  = eff_status;
          ctx_d.epc     = eff_epc;
`ifdef CP0_EXC_BADVADDR_EN
          ctx_d.badvaddr = badvaddr_i;
`endif
          if (req.is_eret) begin
            state_d = WR_STATUS;
          end
`ifdef CP0_EXC_BADVADDR_EN
          // BadVAddr is only meaningful for address errors; other causes leave it untouched.
          else if (req.code == EXC_ADEL || req.code == EXC_ADES) begin
            state_d = WR_BADVADDR;
          end
`endif
          else begin
            state_d = WR_EPC;
          end
        end
      end
      WR_BADVADDR: state_d = WR_EPC;
      WR_EPC:      state_d = WR_CAUSE;
      WR_CAUSE:    state_d = WR_STATUS;
      WR_STATUS:   state_d = REDIRECT;
      REDIRECT:    state_d = IDLE;
      default:     state_d = IDLE;
    endcase
  end

`ifndef CP0_EXC_BADVADDR_EN
  logic unused_badvaddr;
  assign unused_badvaddr = ^badvaddr_i;
`endif

  // Outputs are forced to zero while rst is high so a mid-commit reset emits no further writes.
  always_comb begin
    cp0_we_o    = 1'b0;
    cp0_waddr_o = '0;
    cp0_data_o  = '0;
    cp0_hw_o    = 1'b0;
    stall_o     = 1'b0;
    flush_o     = 1'b0;
    new_pc_o    = '0;
    busy_o      = 1'b0;
    if (!rst) begin
      busy_o = (state_q != IDLE);
      unique case (state_q)
        IDLE: stall_o = det;
        WR_BADVADDR: begin
          stall_o     = 1'b1;
          cp0_we_o    = 1'b1;
          cp0_hw_o    = 1'b1;
          cp0_waddr_o = CP0_BADVADDR;
          cp0_data_o  = ctx_q.badvaddr;
        end
        WR_EPC: begin
          stall_o = 1'b1;
          if (!ctx_q.status[STATUS_EXL]) begin
            cp0_we_o    = 1'b1;
            cp0_hw_o    = 1'b1;
            cp0_waddr_o = CP0_EPC;
            cp0_data_o  = ctx_q.in_ds ? (ctx_q.pc - 32'd4) : ctx_q.pc;
          end
        end
        WR_CAUSE: begin
          stall_o         = 1'b1;
          cp0_we_o        = 1'b1;
          cp0_hw_o        = 1'b1;
          cp0_waddr_o     = CP0_CAUSE;
          cp0_data_o      = ctx_q.cause;
          cp0_data_o[6:2] = ctx_q.code;
          if (!ctx_q.status[STATUS_EXL]) begin
            cp0_data_o[31] = ctx_q.in_ds;
          end
        end
        WR_STATUS: begin
          stall_o     = 1'b1;
          cp0_we_o    = 1'b1;
          cp0_hw_o    = 1'b1;
          cp0_waddr_o = CP0_STATUS;
          cp0_data_o  = ctx_q.is_eret ? (ctx_q.status & ~32'h0000_0002)
                                      : (ctx_q.status |  32'h0000_0002);
        end
        REDIRECT: begin
          flush_o  = 1'b1;
          new_pc_o = ctx_q.is_eret ? ctx_q.epc : EXC_VECTOR;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Directed scoreboard bench for cp0_exc_ctrl: per-cycle expected output tuples are queued and checked at negedge.
module tb_cp0_exc_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i;
  logic [31:0] excepttype_i;
  logic [31:0] pc_i;
  logic        in_delayslot_i;
  logic [31:0] badvaddr_i;
  logic [31:0] status_i, cause_i, epc_i;
  logic        wb_cp0_we_i;
  logic [4:0]  wb_cp0_waddr_i;
  logic [31:0] wb_cp0_data_i;
  logic        cp0_we_o;
  logic [4:0]  cp0_waddr_o;
  logic [31:0] cp0_data_o;
  logic        cp0_hw_o, stall_o, flush_o, busy_o;
  logic [31:0] new_pc_o;

  always #5 clk = ~clk;

  cp0_exc_ctrl #(.EXC_VECTOR(32'h0000_0020)) dut (
    .clk            (clk),
    .rst            (rst),
    .valid_i        (valid_i),
    .excepttype_i   (excepttype_i),
    .pc_i           (pc_i),
    .in_delayslot_i (in_delayslot_i),
    .badvaddr_i     (badvaddr_i),
    .status_i       (status_i),
    .cause_i        (cause_i),
    .epc_i          (epc_i),
    .wb_cp0_we_i    (wb_cp0_we_i),
    .wb_cp0_waddr_i (wb_cp0_waddr_i),
    .wb_cp0_data_i  (wb_cp0_data_i),
    .cp0_we_o       (cp0_we_o),
    .cp0_waddr_o    (cp0_waddr_o),
    .cp0_data_o     (cp0_data_o),
    .cp0_hw_o       (cp0_hw_o),
    .stall_o        (stall_o),
    .flush_o        (flush_o),
    .new_pc_o       (new_pc_o),
    .busy_o         (busy_o)
  );

  typedef struct packed {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] data;
    logic        hw;
    logic        stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        busy;
  } obs_t;

  obs_t obs;
  assign obs = {cp0_we_o, cp0_waddr_o, cp0_data_o, cp0_hw_o, stall_o, flush_o, new_pc_o, busy_o};

  obs_t  exp_q[$];
  string tag_q[$];
  int unsigned n_cmp = 0;
  int unsigned n_mis = 0;

  function automatic obs_t o_idle();
    return '0;
  endfunction

  function automatic obs_t o_det();
    obs_t o = '0;
    o.stall = 1'b1;
    return o;
  endfunction

  function automatic obs_t o_hold();
    obs_t o = '0;
    o.stall = 1'b1;
    o.busy  = 1'b1;
    return o;
  endfunction

  function automatic obs_t o_wr(input logic [4:0] a, input logic [31:0] d);
    obs_t o = '0;
    o.we    = 1'b1;
    o.waddr = a;
    o.data  = d;
    o.hw    = 1'b1;
    o.stall = 1'b1;
    o.busy  = 1'b1;
    return o;
  endfunction

  function automatic obs_t o_redir(input logic [31:0] pc);
    obs_t o = '0;
    o.flush  = 1'b1;
    o.new_pc = pc;
    o.busy   = 1'b1;
    return o;
  endfunction

  task automatic expect_out(input string t, input obs_t e);
    exp_q.push_back(e);
    tag_q.push_back(t);
  endtask

  task automatic tick();
    obs_t  e;
    string t;
    @(negedge clk);
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_mis++;
      $error("FAIL scoreboard_underflow: observed=%h required=<queued entry>", obs);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      assert (obs === e) else begin
        n_mis++;
        $error("FAIL %s: observed=%h required=%h", t, obs, e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic present(input logic [31:0] pc, input logic ds, input logic [31:0] et);
    valid_i        = 1'b1;
    pc_i           = pc;
    in_delayslot_i = ds;
    excepttype_i   = et;
  endtask

  task automatic quiet();
    valid_i      = 1'b0;
    excepttype_i = '0;
    wb_cp0_we_i  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst = 1'b1;
    quiet();
    pc_i = '0; in_delayslot_i = 1'b0; badvaddr_i = 32'hDEAD_BEEF;
    status_i = '0; cause_i = '0; epc_i = '0;
    wb_cp0_waddr_i = '0; wb_cp0_data_i = '0;
    @(posedge clk); #1;

    // Reset state
    expect_out("reset_outputs", o_idle()); tick();
    rst = 1'b0;
    expect_out("idle_after_reset", o_idle()); tick();

    // Syscall at 0x100, no delay slot
    status_i = 32'h1000_0000; cause_i = '0;
    present(32'h0000_0100, 1'b0, 32'h1 << 8);
    expect_out("sys_detect", o_det());
    expect_out("sys_epc",    o_wr(5'd14, 32'h0000_0100));
    expect_out("sys_cause",  o_wr(5'd13, 32'h0000_0020));
    expect_out("sys_status", o_wr(5'd12, 32'h1000_0002));
    expect_out("sys_flush",  o_redir(32'h0000_0020));
    expect_out("sys_idle",   o_idle());
    tick(); quiet(); run(5);

    // Overflow in delay slot; a different request held during commit is ignored
    status_i = '0; cause_i = '0;
    present(32'h0000_0208, 1'b1, 32'h1 << 11);
    expect_out("ov_detect", o_det());
    expect_out("ov_epc",    o_wr(5'd14, 32'h0000_0204));
    expect_out("ov_cause",  o_wr(5'd13, 32'h8000_0030));
    expect_out("ov_status", o_wr(5'd12, 32'h0000_0002));
    expect_out("ov_flush",  o_redir(32'h0000_0020));
    expect_out("ov_idle",   o_idle());
    tick(); excepttype_i = 32'h1 << 8; run(3); quiet(); run(2);

    // Interrupt beats a simultaneous trap
    status_i = 32'h0000_0401; cause_i = 32'h0000_0400;
    present(32'h0000_0300, 1'b0, 32'h1 << 10);
    expect_out("int_detect", o_det());
    expect_out("int_epc",    o_wr(5'd14, 32'h0000_0300));
    expect_out("int_cause",  o_wr(5'd13, 32'h0000_0400));
    expect_out("int_status", o_wr(5'd12, 32'h0000_0403));
    expect_out("int_flush",  o_redir(32'h0000_0020));
    expect_out("int_idle",   o_idle());
    tick(); quiet(); cause_i = '0; run(5);

    // EXL already set: EPC write dropped, Cause[31] kept despite delay slot
    status_i = 32'h0000_0003; cause_i = '0;
    present(32'h0000_0400, 1'b1, 32'h1 << 9);
    expect_out("exl_detect", o_det());
    expect_out("exl_no_epc", o_hold());
    expect_out("exl_cause",  o_wr(5'd13, 32'h0000_0028));
    expect_out("exl_status", o_wr(5'd12, 32'h0000_0003));
    expect_out("exl_flush",  o_redir(32'h0000_0020));
    expect_out("exl_idle",   o_idle());
    tick(); quiet(); run(5);

    // eret returns to EPC
    status_i = 32'h0000_0003; epc_i = 32'h0000_0340;
    present(32'h0000_0500, 1'b0, 32'h1 << 12);
    expect_out("eret_detect", o_det());
    expect_out("eret_status", o_wr(5'd12, 32'h0000_0001));
    expect_out("eret_flush",  o_redir(32'h0000_0340));
    expect_out("eret_idle",   o_idle());
    tick(); quiet(); run(3);

    // eret with a same-cycle WB write to EPC takes the forwarded value
    status_i = 32'h0000_0002;
    present(32'h0000_0504, 1'b0, 32'h1 << 12);
    wb_cp0_we_i = 1'b1; wb_cp0_waddr_i = 5'd14; wb_cp0_data_i = 32'h0000_0380;
    expect_out("fwd_eret_detect", o_det());
    expect_out("fwd_eret_status", o_wr(5'd12, 32'h0000_0000));
    expect_out("fwd_eret_flush",  o_redir(32'h0000_0380));
    tick(); quiet(); run(2);

    // WB mtc0 clearing IE masks a pending interrupt
    status_i = 32'h0000_0401; cause_i = 32'h0000_0400;
    present(32'h0000_0600, 1'b0, '0);
    wb_cp0_we_i = 1'b1; wb_cp0_waddr_i = 5'd12; wb_cp0_data_i = 32'h0000_0400;
    expect_out("mask_no_detect", o_idle());
    expect_out("mask_still_idle", o_idle());
    tick(); quiet(); cause_i = '0; tick();

    // Reset in WR_CAUSE abandons the commit
    status_i = '0; cause_i = '0;
    present(32'h0000_0700, 1'b0, 32'h1 << 8);
    expect_out("rst_detect",   o_det());
    expect_out("rst_epc",      o_wr(5'd14, 32'h0000_0700));
    expect_out("rst_in_cause", o_idle());
    expect_out("rst_after_1",  o_idle());
    expect_out("rst_after_2",  o_idle());
    tick(); quiet(); tick();
    rst = 1'b1; tick();
    rst = 1'b0; run(2);

    n_cmp++;
    assert (exp_q.size() == 0) else begin
      n_mis++;
      $error("FAIL scoreboard_drain: observed=%0d left required=0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/cp0_exc_ctrl.md
Name: cp0_exc_ctrl

Overview:
- Exception sequencer on the consumer side of the CP0 register block.
- Reads Status/Cause/EPC from CP0 and qualifies them with the latest WB-stage mtc0 write.
- Prioritises the MEM-stage exception request.
- Drives the CP0 write port through a fixed multi-cycle commit (EPC, Cause, Status), then flushes the pipeline and redirects the PC to the exception vector, or to EPC for eret.

Parameters:
- EXC_VECTOR, 32'h0000_0020, handler entry PC for all exceptions.
- COMMIT_CYCLES, 4, cycles from detection to flush pulse. Fixed; documented only, not overridable.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- valid_i  in  1  MEM-stage instruction valid
- excepttype_i  in  32  exception flags: bit8 syscall, bit9 invalid inst, bit10 trap, bit11 overflow, bit12 eret, bit13 AdEL, bit14 AdES
- pc_i  in  32  MEM-stage instruction PC
- in_delayslot_i  in  1  instruction is in a branch delay slot
- badvaddr_i  in  32  faulting data address
- status_i / cause_i / epc_i  in  32 each  current CP0 register values
- wb_cp0_we_i  in  1  WB-stage mtc0 write enable (forwarding)
- wb_cp0_waddr_i  in  5  WB-stage mtc0 address
- wb_cp0_data_i  in  32  WB-stage mtc0 data
- cp0_we_o  out  1  CP0 write enable
- cp0_waddr_o  out  5  CP0 write address
- cp0_data_o  out  32  CP0 write data
- cp0_hw_o  out  1  hardware write: CP0 writes every bit of the addressed register, ignoring mtc0 field masks
- stall_o  out  1  holds the pipeline while committing
- flush_o  out  1  one-cycle flush pulse
- new_pc_o  out  32  redirect PC, valid while flush_o=1
- busy_o  out  1  FSM not in IDLE

Behaviour:
- Forwarding: effective Status/Cause/EPC = wb_cp0_data_i when wb_cp0_we_i=1 and the address matches 12/13/14; otherwise the *_i value.
- Interrupt pending: (Cause[15:8] & Status[15:8]) != 0 and Status[0]=1 and Status[1]=0.
- Priority when valid_i=1: interrupt (code 0) > AdEL (4) > AdES (5) > syscall (8) > invalid inst (10) > trap (13) > overflow (12) > eret.
- valid_i=0: no detection.
- FSM states: IDLE, WR_BADVADDR, WR_EPC, WR_CAUSE, WR_STATUS, REDIRECT.
- IDLE, on detection at cycle N:
  - Latch pc_i, in_delayslot_i, the code, eff Cause and eff Status.
  - stall_o=1 combinationally in cycle N.
  - Next state WR_EPC, or WR_STATUS for eret.
- WR_EPC (N+1):
  - we=1, addr 14, hw=1.
  - data = in_delayslot ? pc-4 : pc.
  - If latched Status.EXL=1, drop we; EPC is unchanged.
- WR_CAUSE (N+2):
  - addr 13, hw=1.
  - data = latched Cause with [31]=in_delayslot and [6:2]=code.
  - If EXL was already 1, bit31 is unchanged.
- WR_STATUS (N+3):
  - Exception: data = latched Status | 32'h2.
  - eret: data = latched Status & ~32'h2.
- REDIRECT (N+4):
  - flush_o=1, stall_o=0, new_pc_o = EXC_VECTOR, or the EPC value for eret.
  - Next state IDLE.
- eret latency is N+2: IDLE, WR_STATUS, REDIRECT.
- The EPC value used for eret is eff EPC captured at detection.
- stall_o=1 in every non-IDLE state except REDIRECT.
- Outputs in states with no write: cp0_we_o=0, cp0_waddr_o=0, cp0_data_o=0, cp0_hw_o=0.
- Requests while busy are ignored; the pipeline is stalled, so the request is re-presented.
- Detection in the cycle flush_o=1 is suppressed.
- Reset values of all outputs: 0. FSM returns to IDLE.
- Reset mid-commit abandons remaining writes; no further cp0_we_o pulses occur.
- Simultaneous WB mtc0 write and detection: the forwarded value wins.

Optional Feature:
- Macro: CP0_EXC_BADVADDR_EN.
- Defined:
  - AdEL/AdES (bits 13/14) are recognised.
  - The FSM inserts WR_BADVADDR (addr 8, hw=1, data=badvaddr_i latched at detection) before WR_EPC.
  - Exception latency becomes N+5.
- Undefined:
  - Bits 13/14 and badvaddr_i are ignored.
  - WR_BADVADDR is unreachable.
  - Ports remain present.

Decomposition:
- defines.v holds:
  - CP0 register addresses: BadVAddr 8, Status 12, Cause 13, EPC 14.
  - ExcCode constants.
  - excepttype bit positions.
  - FSM state encodings.
  - EXL/IE bit indices.
- Sub-module exc_prio_enc: combinational forwarding plus priority encoder producing {hit, is_eret, code[4:0]}.

Test Plan:
- Syscall at pc=0x100, not in delay slot, Status=0x1000_0000:
  - N+1: we addr14 data 0x100.
  - N+2: addr13 ExcCode=8.
  - N+3: addr12 data 0x1000_0002.
  - N+4: flush, new_pc=0x20.
- Overflow in delay slot, pc=0x208: EPC=0x204 and Cause[31]=1.
- Status=0x0000_0401, Cause IP2 set, simultaneous trap flag: interrupt wins (code 0); trap is not committed.
- EXL=1 then invalid inst: no EPC write at N+1; Cause code 10 written; flush at N+4.
- eret with EPC=0x340:
  - N+1: Status write clears bit1.
  - N+2: flush, new_pc=0x340.
- WB mtc0 to Status (IE=0) in the detection cycle masks a pending interrupt: no commit. Separately, rst asserted in WR_CAUSE: no further writes and all outputs are 0.
